q69_mac_feeder: RTL and testbench



---
 rtl/q69_pkg.sv | 11 +
 rtl/q69_round_sat.sv | 38 +++
 rtl/q69_mac_feeder.sv | 94 +++++++++
 tb/tb_q69_mac_feeder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/q69_pkg.sv
// Shared Q6.9 fixed-point constants and the MAC feeder state encoding.
package q69_pkg;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 9;

  localparam logic [15:0] Q69_MAX = 16'h7fff;
  localparam logic [15:0] Q69_MIN = 16'h8000;
  localparam logic [15:0] Q69_ONE = 16'h0200;

  typedef enum logic [1:0] {S_ACC, S_RND, S_OUT} state_e;
endpackage

// File: rtl/q69_round_sat.sv
// Reduces a full-precision Q accumulator to a saturated Q6.9 word.
// MAC_ROUND_EN selects round-half-up; otherwise the result is truncated toward -inf.
module q69_round_sat #(
  parameter int DATA_W = q69_pkg::DATA_W,
  parameter int FRAC_W = q69_pkg::FRAC_W,
  parameter int ACC_W  = 40
) (
  input  logic [ACC_W-1:0]  i_acc,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sat
);
  localparam int Q_W = ACC_W + 1 - FRAC_W;

  logic [ACC_W:0]         w_ext;
  logic [ACC_W:0]         w_rnd;
  logic [Q_W-1:0]         w_q;
  logic [Q_W-DATA_W:0]    w_hi;

  // One guard bit so the rounding increment can never wrap the sign.
  assign w_ext = {i_acc[ACC_W-1], i_acc};
`ifdef MAC_ROUND_EN
  assign w_rnd = w_ext + ((ACC_W+1)'(1) << (FRAC_W-1));
`else
  assign w_rnd = w_ext;
`endif
  assign w_q  = w_rnd[ACC_W:FRAC_W];
  assign w_hi = w_q[Q_W-1:DATA_W-1];

  // In range exactly when every bit above the result's sign matches it.
  always_comb begin
    o_sat  = 1'b0;
    o_data = w_q[DATA_W-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      o_sat  = 1'b1;
      o_data = w_q[Q_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
endmodule

// File: rtl/q69_mac_feeder.sv
// Q6.9 multiply-accumulate feeder: LEN (a,w) beats plus bias, rounded and
// saturated into one result presented on a valid/ready output port.
module q69_mac_feeder
  import q69_pkg::*;
#(
  parameter int DATA_W = q69_pkg::DATA_W,
  parameter int FRAC_W = q69_pkg::FRAC_W,
  parameter int LEN    = 16,
  parameter int ACC_W  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_w,
  input  logic [DATA_W-1:0] in_bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sat
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

  state_e              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic                r_valid;
  logic [DATA_W-1:0]   r_data;
  logic                r_sat;

  logic signed [2*DATA_W-1:0] w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W-1:0]    w_bias;
  logic [ACC_W-1:0]    w_base;
  logic                w_beat;
  logic                w_last;
  logic [DATA_W-1:0]   w_rs_data;
  logic                w_rs_sat;

  assign in_ready   = (r_state == S_ACC);
  assign w_beat     = in_valid && in_ready;
  assign w_last     = (r_cnt == CNT_W'(LEN-1));

  assign w_prod     = $signed(in_a) * $signed(in_w);
  assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
  // Bias is aligned to the product's 2*FRAC_W fraction bits.
  assign w_bias     = {{(ACC_W-DATA_W-FRAC_W){in_bias[DATA_W-1]}}, in_bias, {FRAC_W{1'b0}}};
  assign w_base     = (r_cnt == '0) ? w_bias : r_acc;

  q69_round_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_rs (
    .i_acc  (r_acc),
    .o_data (w_rs_data),
    .o_sat  (w_rs_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_ACC;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_ACC: if (w_beat) begin
          r_acc <= w_base + w_prod_ext;
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_RND;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_RND: begin
          r_data  <= w_rs_data;
          r_sat   <= w_rs_sat;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          r_valid <= 1'b0;
          r_state <= S_ACC;
        end
        default: r_state <= S_ACC;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_sat   = r_sat;
endmodule

// File: tb/tb_q69_mac_feeder.sv
// Directed bench for q69_mac_feeder: a LEN=4 instance and a LEN=1 instance.
module tb_q69_mac_feeder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a = '0, w = '0, b = '0;
  logic        v4 = 1'b0, v1 = 1'b0, or4 = 1'b1, or1 = 1'b1;
  logic        ir4, ov4, os4, ir1, ov1, os1;
  logic [15:0] od4, od1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  q69_mac_feeder #(.LEN(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_a(a), .in_w(w),
    .in_bias(b), .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_sat(os4)
  );

  q69_mac_feeder #(.LEN(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in_a(a), .in_w(w),
    .in_bias(b), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_sat(os1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic feed4(input logic [15:0] fa, input logic [15:0] fw,
                       input logic [15:0] b0, input logic [15:0] bn);
    for (int i = 0; i < 4; i++) begin
      a = fa; w = fw; b = (i == 0) ? b0 : bn; v4 = 1'b1;
      tick();
    end
    v4 = 1'b0;
  endtask

  task automatic wait4(input string tag);
    int k = 0;
    while (!ov4 && k < 20) begin tick(); k++; end
    chk(tag, {31'd0, ov4}, 32'd1);
  endtask

  task automatic wait1(input string tag);
    int k = 0;
    while (!ov1 && k < 20) begin tick(); k++; end
    chk(tag, {31'd0, ov1}, 32'd1);
  endtask

  task automatic run1(input logic [15:0] fa, input logic [15:0] fw,
                      input string tag, input logic [15:0] exp);
    a = fa; w = fw; b = 16'h0000; v1 = 1'b1;
    tick();
    v1 = 1'b0;
    wait1({tag, "_valid"});
    chk(tag, {16'd0, od1}, {16'd0, exp});
    chk({tag, "_sat"}, {31'd0, os1}, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    tick(); tick();
    chk("rst_in_ready", {31'd0, ir4}, 32'd1);
    chk("rst_out_valid", {31'd0, ov4}, 32'd0);
    chk("rst_out_data", {16'd0, od4}, 32'd0);
    chk("rst_out_sat", {31'd0, os4}, 32'd0);
    rst = 1'b1;
    tick();

    // 4 x (1.0 * 0.5) = 2.0, with exact latency
    feed4(16'h0200, 16'h0100, 16'h0000, 16'h0000);
    chk("lat_t1_valid", {31'd0, ov4}, 32'd0);
    chk("lat_t1_ready", {31'd0, ir4}, 32'd0);
    tick();
    chk("lat_t2_valid", {31'd0, ov4}, 32'd1);
    chk("lat_t2_ready", {31'd0, ir4}, 32'd0);
    chk("basic_data", {16'd0, od4}, 32'h0400);
    chk("basic_sat", {31'd0, os4}, 32'd0);
    tick();
    chk("basic_done_valid", {31'd0, ov4}, 32'd0);
    chk("basic_done_ready", {31'd0, ir4}, 32'd1);

    feed4(16'h7fff, 16'h7fff, 16'h0000, 16'h0000);
    wait4("pos_valid");
    chk("pos_sat_data", {16'd0, od4}, 32'h7fff);
    chk("pos_sat_flag", {31'd0, os4}, 32'd1);
    tick();

    feed4(16'h8000, 16'h7fff, 16'h0000, 16'h0000);
    wait4("neg_valid");
    chk("neg_sat_data", {16'd0, od4}, 32'h8000);
    chk("neg_sat_flag", {31'd0, os4}, 32'd1);
    tick();

    // Bias only taken on the first beat
    feed4(16'h0000, 16'h1234, 16'hff00, 16'h0200);
    wait4("bias_valid");
    chk("bias_data", {16'd0, od4}, 32'hff00);
    chk("bias_sat", {31'd0, os4}, 32'd0);
    tick();

`ifdef MAC_ROUND_EN
    run1(16'h0001, 16'h0100, "len1_pos_half", 16'h0001);
    run1(16'h0001, 16'hff00, "len1_neg_half", 16'h0000);
`else
    run1(16'h0001, 16'h0100, "len1_pos_half", 16'h0000);
    run1(16'h0001, 16'hff00, "len1_neg_half", 16'hffff);
`endif

    // Backpressure: hold result, ignore in_valid pulses during the stall
    or4 = 1'b0;
    feed4(16'h0200, 16'h0100, 16'h0000, 16'h0000);
    wait4("bp_valid");
    for (int i = 0; i < 5; i++) begin
      a = 16'h7fff; w = 16'h7fff; b = 16'h7fff; v4 = i[0];
      tick();
      chk("bp_hold_valid", {31'd0, ov4}, 32'd1);
      chk("bp_hold_data", {16'd0, od4}, 32'h0400);
      chk("bp_hold_sat", {31'd0, os4}, 32'd0);
      chk("bp_hold_ready", {31'd0, ir4}, 32'd0);
    end
    v4 = 1'b0; or4 = 1'b1;
    tick();
    chk("bp_release_valid", {31'd0, ov4}, 32'd0);
    chk("bp_release_ready", {31'd0, ir4}, 32'd1);
    feed4(16'h0200, 16'h0100, 16'h0000, 16'h0000);
    wait4("bp_after_valid");
    chk("bp_after_data", {16'd0, od4}, 32'h0400);
    tick();

    // Reset after 2 of 4 beats discards the partial sum
    for (int i = 0; i < 2; i++) begin
      a = 16'h7fff; w = 16'h7fff; b = 16'h4000; v4 = 1'b1;
      tick();
    end
    v4 = 1'b0; rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("midrst_valid", {31'd0, ov4}, 32'd0);
    chk("midrst_ready", {31'd0, ir4}, 32'd1);
    feed4(16'h0200, 16'h0100, 16'h0000, 16'h0000);
    wait4("midrst_after_valid");
    chk("midrst_after_data", {16'd0, od4}, 32'h0400);
    chk("midrst_after_sat", {31'd0, os4}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
